iota_rc_seq: RTL and testbench

- Sequential, parametrised iota stage for the Keccak-p permutation family.
- Replaces the fixed 64-bit round-constant lookup with an on-the-fly LFSR round-constant generator.
- Supports lane widths 8/16/32/64 (Keccak-f[200..1600]) and reduced-round variants that start at an arbitrary round, e.g. 12-round KangarooTwelve.
- Sits after chi in the round datapath. Consumes lane (0,0) once per round over a valid/ready handshake, XORs in the current round constant, and advances to the next round.

---
 rtl/iota_rc_seq.sv | 129 ++++++++++++
 tb/tb_iota_rc_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iota_rc_seq.sv
// Sequential Keccak-p iota stage: XORs an on-the-fly LFSR round constant into
// lane (0,0) once per round over valid/ready handshakes on both sides.
module iota_rc_seq #(
  parameter int LANE_W      = 64,
  parameter int NUM_ROUNDS  = 24,
  parameter int FIRST_ROUND = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_data,
  output logic [4:0]        out_round,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int L          = $clog2(LANE_W);
  localparam int LAST_ROUND = FIRST_ROUND + NUM_ROUNDS - 1;
  localparam logic [4:0] FIRST_R = 5'(FIRST_ROUND);
  localparam logic [4:0] LAST_R  = 5'(LAST_ROUND);

  // One rc(t) LFSR step: shift up, feed the bit shifted out back into taps 0,4,5,6.
  function automatic logic [7:0] lfsr_step(input logic [7:0] r);
    logic       fb;
    logic [7:0] n;
    fb   = r[7];
    n    = {r[6:0], fb};
    n[4] = n[4] ^ fb;
    n[5] = n[5] ^ fb;
    n[6] = n[6] ^ fb;
    return n;
  endfunction

  function automatic logic [7:0] lfsr_advance(input logic [7:0] r, input int steps);
    logic [7:0] s;
    s = r;
    for (int i = 0; i < steps; i++) s = lfsr_step(s);
    return s;
  endfunction

  localparam logic [7:0] LFSR_INIT = lfsr_advance(8'h01, 7 * FIRST_ROUND);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_next;
  logic [7:0]          lfsr, lfsr_next;
  logic [4:0]          round;
  logic [6:0]          rc_bits;
  logic [LANE_W-1:0]   rc_lane;
  logic                xfer;
  logic                is_last;

  assign in_ready = (state == RUN) && !start && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;
  assign is_last  = (round == LAST_R);
  assign busy     = (state == RUN) || out_valid;

  // Seven rc bits per round come straight off the LFSR chain; the end of the
  // chain is the state for the next round.
  always_comb begin
    logic [7:0] s;
    s       = lfsr;
    rc_bits = '0;
    for (int j = 0; j < 7; j++) begin
      rc_bits[j] = s[0];
      s = lfsr_step(s);
    end
    lfsr_next = s;
  end

  always_comb begin
    rc_lane = '0;
    for (int j = 0; j <= L; j++) rc_lane[(2 ** j) - 1] = rc_bits[j];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (start)                 state_next = RUN;
        else if (xfer && is_last)  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output register and round tracking; a start always rewinds to FIRST_ROUND.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= LFSR_INIT;
      round     <= FIRST_R;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_round <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= out_valid && out_ready && out_last;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data ^ rc_lane;
        out_round <= round;
        out_last  <= is_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (start || (xfer && is_last)) begin
        lfsr  <= LFSR_INIT;
        round <= FIRST_R;
      end else if (xfer) begin
        lfsr  <= lfsr_next;
        round <= round + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_iota_rc_seq.sv
// Bench for iota_rc_seq: three configurations (64/24/0, 8/18/0, 64/12/12)
// share stimulus and are checked every cycle against a spec-level model.
module tb_iota_rc_seq;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [63:0] in_data;

  always #5 clk = ~clk;

  logic        a_ir, a_ov, a_ol, a_busy, a_done;
  logic [63:0] a_od;
  logic [4:0]  a_or;
  logic        b_ir, b_ov, b_ol, b_busy, b_done;
  logic [7:0]  b_od;
  logic [4:0]  b_or;
  logic        c_ir, c_ov, c_ol, c_busy, c_done;
  logic [63:0] c_od;
  logic [4:0]  c_or;

  iota_rc_seq #(.LANE_W(64), .NUM_ROUNDS(24), .FIRST_ROUND(0)) dut64 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(a_ir),
    .in_data(in_data), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od),
    .out_round(a_or), .out_last(a_ol), .busy(a_busy), .done(a_done));

  iota_rc_seq #(.LANE_W(8), .NUM_ROUNDS(18), .FIRST_ROUND(0)) dut8 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_ir),
    .in_data(in_data[7:0]), .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od),
    .out_round(b_or), .out_last(b_ol), .busy(b_busy), .done(b_done));

  iota_rc_seq #(.LANE_W(64), .NUM_ROUNDS(12), .FIRST_ROUND(12)) dutk12 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(c_ir),
    .in_data(in_data), .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od),
    .out_round(c_or), .out_last(c_ol), .busy(c_busy), .done(c_done));

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // rc(t) straight from the FIPS 202 definition, restarting from 0x01 each call.
  function automatic logic rc_bit(input int t);
    logic [8:0] r;
    r = 9'h001;
    for (int i = 0; i < (t % 255); i++) begin
      r    = {r[7:0], 1'b0};
      r[0] = r[0] ^ r[8];
      r[4] = r[4] ^ r[8];
      r[5] = r[5] ^ r[8];
      r[6] = r[6] ^ r[8];
      r[8] = 1'b0;
    end
    return r[0];
  endfunction

  function automatic logic [63:0] rc64(input int rnd);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < 7; j++) v[(1 << j) - 1] = rc_bit(j + 7 * rnd);
    return v;
  endfunction

  int          first_r [3] = '{0, 0, 12};
  int          num_r   [3] = '{24, 18, 12};
  logic [63:0] mask    [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFF, 64'hFFFF_FFFF_FFFF_FFFF};

  bit          m_run   [3];
  int          m_round [3];
  bit          m_pv    [3];
  logic [63:0] m_pdata [3];
  int          m_pround[3];
  bit          m_plast [3];
  bit          m_done  [3];

  // Model: a permutation is a run of rounds; one output slot holds at most one beat.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_run[d] = 0; m_round[d] = first_r[d]; m_pv[d] = 0;
        m_pdata[d] = '0; m_pround[d] = 0; m_plast[d] = 0; m_done[d] = 0;
      end else begin
        bit ir, xf, nd, lastr;
        ir    = m_run[d] && !start && (!m_pv[d] || out_ready);
        xf    = ir && in_valid;
        nd    = m_pv[d] && out_ready && m_plast[d];
        lastr = (m_round[d] == first_r[d] + num_r[d] - 1);
        if (xf) begin
          m_pv[d]     = 1;
          m_pdata[d]  = (in_data ^ rc64(m_round[d])) & mask[d];
          m_pround[d] = m_round[d];
          m_plast[d]  = lastr;
        end else if (out_ready) begin
          m_pv[d] = 0;
        end
        if (start) begin
          m_run[d] = 1; m_round[d] = first_r[d];
        end else if (xf) begin
          if (lastr) begin m_run[d] = 0; m_round[d] = first_r[d]; end
          else m_round[d] = m_round[d] + 1;
        end
        m_done[d] = nd;
      end
    end
  end

  logic [63:0] log0[$], log1[$], log2[$];
  int          rnd0[$];
  int          done_cnt[3];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        logic ir, ov, ol, bz, dn;
        logic [63:0] od;
        logic [4:0] ord;
        case (d)
          0: begin ir = a_ir; ov = a_ov; ol = a_ol; bz = a_busy; dn = a_done; od = a_od; ord = a_or; end
          1: begin ir = b_ir; ov = b_ov; ol = b_ol; bz = b_busy; dn = b_done; od = {56'd0, b_od}; ord = b_or; end
          default: begin ir = c_ir; ov = c_ov; ol = c_ol; bz = c_busy; dn = c_done; od = c_od; ord = c_or; end
        endcase
        checkOutput($sformatf("dut%0d in_ready", d), {63'd0, ir},
                    {63'd0, m_run[d] && !start && (!m_pv[d] || out_ready)});
        checkOutput($sformatf("dut%0d out_valid", d), {63'd0, ov}, {63'd0, m_pv[d]});
        checkOutput($sformatf("dut%0d busy", d), {63'd0, bz}, {63'd0, m_run[d] || m_pv[d]});
        checkOutput($sformatf("dut%0d done", d), {63'd0, dn}, {63'd0, m_done[d]});
        checkOutput($sformatf("dut%0d out_data", d), od, m_pdata[d]);
        checkOutput($sformatf("dut%0d out_round", d), {59'd0, ord}, 64'(m_pround[d]));
        checkOutput($sformatf("dut%0d out_last", d), {63'd0, ol}, {63'd0, m_plast[d]});
        if (ov && out_ready) begin
          if (d == 0) begin log0.push_back(od); rnd0.push_back(int'(ord)); end
          else if (d == 1) log1.push_back(od);
          else log2.push_back(od);
        end
        if (dn) done_cnt[d]++;
      end
    end
  end

  task automatic applyStimulus(input logic st, input logic iv, input logic [63:0] data, input logic ordy);
    start = st; in_valid = iv; in_data = data; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    log0.delete(); log1.delete(); log2.delete(); rnd0.delete();
    for (int d = 0; d < 3; d++) done_cnt[d] = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    applyStimulus(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    checkOutput("reset out_valid", {63'd0, a_ov}, 64'd0);
    checkOutput("reset busy", {63'd0, a_busy}, 64'd0);

    checkOutput("rc model r0", rc64(0), 64'h0000_0000_0000_0001);
    checkOutput("rc model r1", rc64(1), 64'h0000_0000_0000_8082);
    checkOutput("rc model r2", rc64(2), 64'h8000_0000_0000_808A);
    checkOutput("rc model r12", rc64(12), 64'h0000_0000_8000_808B);
    checkOutput("rc model r23", rc64(23), 64'h8000_0000_8000_8008);
    rst = 1'b0;

    // in_valid while idle must be ignored
    applyStimulus(0, 1, 64'h0, 1);

    // Full-throughput stream with zero lanes
    clearLogs();
    applyStimulus(1, 0, 64'h0, 1);
    repeat (30) applyStimulus(0, 1, 64'h0, 1);
    repeat (3) applyStimulus(0, 0, 64'h0, 1);
    checkOutput("p1 beats64", 64'(log0.size()), 64'd24);
    checkOutput("p1 beats8", 64'(log1.size()), 64'd18);
    checkOutput("p1 beatsk12", 64'(log2.size()), 64'd12);
    if (log0.size() == 24) begin
      checkOutput("p1 rc0", log0[0], 64'h1);
      checkOutput("p1 rc1", log0[1], 64'h8082);
      checkOutput("p1 rc2", log0[2], 64'h8000_0000_0000_808A);
      checkOutput("p1 rc23", log0[23], 64'h8000_0000_8000_8008);
    end
    if (log2.size() == 12) begin
      checkOutput("p1 k12 first", log2[0], 64'h0000_0000_8000_808B);
      checkOutput("p1 k12 last", log2[11], 64'h8000_0000_8000_8008);
    end
    checkOutput("p1 done64", 64'(done_cnt[0]), 64'd1);
    checkOutput("p1 done8", 64'(done_cnt[1]), 64'd1);

    // All-ones lanes, checked on the 8-bit instance
    clearLogs();
    applyStimulus(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    repeat (26) applyStimulus(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    repeat (3) applyStimulus(0, 0, 64'h0, 1);
    checkOutput("p2 beats8", 64'(log1.size()), 64'd18);
    if (log1.size() == 18) begin
      checkOutput("p2 b8 r0", log1[0], 64'hFE);
      checkOutput("p2 b8 r1", log1[1], 64'h7D);
      checkOutput("p2 b8 r2", log1[2], 64'h75);
      checkOutput("p2 b8 r17", log1[17], 64'h7F);
    end

    // Backpressure with out_ready toggling and changing lanes
    clearLogs();
    applyStimulus(1, 0, 64'h0, 1);
    for (int i = 0; i < 64; i++)
      applyStimulus(0, 1, {$urandom, $urandom}, (i % 2) == 0);
    repeat (4) applyStimulus(0, 0, 64'h0, 1);
    checkOutput("p3 beats64", 64'(log0.size()), 64'd24);
    checkOutput("p3 beats8", 64'(log1.size()), 64'd18);
    checkOutput("p3 beatsk12", 64'(log2.size()), 64'd12);
    checkOutput("p3 done64", 64'(done_cnt[0]), 64'd1);

    // Abort after five beats, then a complete run
    clearLogs();
    applyStimulus(1, 0, 64'h0, 1);
    repeat (5) applyStimulus(0, 1, 64'h0, 1);
    applyStimulus(1, 1, 64'h0, 1);
    repeat (30) applyStimulus(0, 1, 64'h0, 1);
    repeat (3) applyStimulus(0, 0, 64'h0, 1);
    checkOutput("p4 beats64", 64'(log0.size()), 64'd29);
    if (log0.size() == 29) begin
      checkOutput("p4 pre-abort round", 64'(rnd0[4]), 64'd4);
      checkOutput("p4 restart round", 64'(rnd0[5]), 64'd0);
      checkOutput("p4 restart data", log0[5], 64'h1);
    end
    checkOutput("p4 done64", 64'(done_cnt[0]), 64'd1);
    checkOutput("p4 beats8", 64'(log1.size()), 64'd23);

    // Reset mid-permutation with a beat pending
    clearLogs();
    applyStimulus(1, 0, 64'h0, 1);
    repeat (11) applyStimulus(0, 1, 64'h0, 1);
    checkOutput("p5 pending valid", {63'd0, a_ov}, 64'd1);
    checkOutput("p5 pending round", {59'd0, a_or}, 64'd10);
    rst = 1'b1;
    applyStimulus(0, 1, 64'h0, 1);
    checkOutput("p5 rst out_valid", {63'd0, a_ov}, 64'd0);
    checkOutput("p5 rst out_data", a_od, 64'd0);
    checkOutput("p5 rst busy", {63'd0, a_busy}, 64'd0);
    rst = 1'b0;
    clearLogs();
    applyStimulus(1, 0, 64'h0, 1);
    repeat (3) applyStimulus(0, 1, 64'h0, 1);
    repeat (2) applyStimulus(0, 0, 64'h0, 1);
    checkOutput("p5 beats64", 64'(log0.size()), 64'd3);
    if (log0.size() > 0) checkOutput("p5 first rc", log0[0], 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
